rggen_register_access_arbiter: RTL and testbench
================================================

RGGEN_REGISTER_ACCESS_ARBITER -- requirements
Module: rggen_register_access_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters (legal range 2..8).
REQ-002 SHALL have parameter WIDTH, default 32, bit-field bus data width.
REQ-003 SHALL have one clock and a synchronous, active-low reset; ports are i_clk and i_rst_n.
REQ-004 SHALL have ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_req_valid  in  N_REQ  per-requester command valid.
- o_req_ready  out  N_REQ  per-requester command accept (grant).
- i_req_write  in  N_REQ  1 = write, 0 = read.
- i_req_strobe  in  N_REQ*WIDTH  per-requester bit mask; requester k uses slice [k*WIDTH +: WIDTH].
- i_req_data  in  N_REQ*WIDTH  per-requester write data; same slicing.
- o_rsp_valid  out  N_REQ  per-requester response valid.
- i_rsp_ready  in  N_REQ  per-requester response accept.
- o_rsp_data  out  WIDTH  response read data, shared by all requesters.
- o_bit_field_valid  out  1  bit-field access strobe.
- o_bit_field_read_mask  out  WIDTH  read mask.
- o_bit_field_write_mask  out  WIDTH  write mask.
- o_bit_field_write_data  out  WIDTH  write data.
- i_bit_field_read_data  in  WIDTH  bit-field read data.

Function
REQ-005 SHALL implement a three-state FSM: IDLE, ACCESS, RESPONSE.
REQ-006 In IDLE, SHALL assert o_req_ready for exactly one requester: the first one with i_req_valid=1, searching round-robin from pointer rr_ptr upward with wrap.
- o_req_ready SHALL be combinational from i_req_valid and rr_ptr.
- o_req_ready SHALL be all-zero outside IDLE.
REQ-007 On a grant (valid & ready):
- SHALL register the winner index g, its write flag, strobe and data;
- SHALL set rr_ptr to (g+1) mod N_REQ;
- SHALL enter ACCESS on the next cycle.
REQ-008 In ACCESS, SHALL assert o_bit_field_valid for exactly one cycle.
- Write: o_bit_field_write_mask = strobe, o_bit_field_write_data = data, o_bit_field_read_mask = 0.
- Read: o_bit_field_read_mask = strobe, write mask = 0, write data = 0.
REQ-009 Outside ACCESS, SHALL drive o_bit_field_valid, both masks and write data to 0.
REQ-010 In ACCESS, SHALL capture i_bit_field_read_data & read_mask into the response register for reads, and 0 for writes; SHALL then enter RESPONSE.
REQ-011 In RESPONSE, SHALL hold o_rsp_valid[g]=1, all other o_rsp_valid bits 0, and o_rsp_data stable until i_rsp_ready[g]=1.
- On that cycle it SHALL return to IDLE.
- i_rsp_ready bits other than g SHALL be ignored.
REQ-012 SHALL drive o_rsp_data = 0 whenever no o_rsp_valid bit is set.
REQ-013 Latency SHALL be fixed:
- grant in cycle T;
- o_bit_field_valid in T+1;
- o_rsp_valid from T+2;
- next grant no earlier than the cycle after response accept.
- Minimum period is 3 cycles per access.
REQ-014 A requester whose i_req_valid drops before grant SHALL simply not be granted; no command SHALL be lost once granted.
REQ-015 A strobe of all-zero SHALL still be sequenced through ACCESS and RESPONSE (o_bit_field_valid=1 with zero masks).
REQ-016 rr_ptr SHALL advance only on grant; an idle cycle with no valid SHALL leave it unchanged.

Reset
REQ-017 While i_rst_n=0 at a rising edge, SHALL synchronously set state=IDLE, rr_ptr=0, and the command and response registers to 0.
REQ-018 After reset, o_req_ready SHALL be combinational per REQ-006 with rr_ptr=0. All other outputs SHALL be 0.
REQ-019 Reset asserted in ACCESS or RESPONSE SHALL abort the transaction:
- no o_bit_field_valid and no o_rsp_valid in the cycle after the reset edge;
- the pending response SHALL be discarded.

Verification
REQ-020 N_REQ=2, WIDTH=32. After reset, req0 write, strobe 0x0000FFFF, data 0x12345678 -> ready0 in T; o_bit_field_valid in T+1 with write_mask 0x0000FFFF, write_data 0x12345678, read_mask 0; rsp_valid0 in T+2 with rsp_data 0.
REQ-021 Read, strobe 0xFF00FF00, i_bit_field_read_data 0xAABBCCDD -> read_mask 0xFF00FF00 in T+1; rsp_data 0xAA00CC00 from T+2.
REQ-022 Both requesters valid continuously, i_rsp_ready tied 1 -> grants alternate 0,1,0,1; a grant every 3 cycles; each o_bit_field_valid is a 1-cycle pulse.
REQ-023 i_rsp_ready0 held 0 for 5 cycles in RESPONSE, i_rsp_ready1=1, req1 valid -> rsp_valid0 and rsp_data stable all 5 cycles; no grant to req1 until the cycle after ready0 rises.
REQ-024 Reset pulsed during RESPONSE -> next cycle: all o_rsp_valid=0, state IDLE; simultaneous req0 and req1 valid -> req0 granted (rr_ptr=0).
REQ-025 N_REQ=4: only req3 valid, then only req1 -> req3 granted, then req1 (pointer wraps 3->0); rr_ptr unchanged across intervening idle cycles.

Source files
------------

// File: rtl/rggen_register_access_arbiter.sv
// Round-robin arbiter that funnels N_REQ register-access requesters onto a
// single bit-field access port. Each access is a fixed three-phase sequence:
// grant (IDLE), one-cycle bit-field strobe (ACCESS), held response (RESPONSE).
module rggen_register_access_arbiter #(
    parameter int N_REQ = 2,
    parameter int WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req_valid,
    output logic [N_REQ-1:0]       o_req_ready,
    input  logic [N_REQ-1:0]       i_req_write,
    input  logic [N_REQ*WIDTH-1:0] i_req_strobe,
    input  logic [N_REQ*WIDTH-1:0] i_req_data,
    output logic [N_REQ-1:0]       o_rsp_valid,
    input  logic [N_REQ-1:0]       i_rsp_ready,
    output logic [WIDTH-1:0]       o_rsp_data,
    output logic                   o_bit_field_valid,
    output logic [WIDTH-1:0]       o_bit_field_read_mask,
    output logic [WIDTH-1:0]       o_bit_field_write_mask,
    output logic [WIDTH-1:0]       o_bit_field_write_data,
    input  logic [WIDTH-1:0]       i_bit_field_read_data
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCESS   = 2'd1;
    localparam logic [1:0] RESPONSE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] cmd_idx_q, cmd_idx_d;
    logic             cmd_write_q, cmd_write_d;
    logic [WIDTH-1:0] cmd_strobe_q, cmd_strobe_d;
    logic [WIDTH-1:0] cmd_data_q, cmd_data_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_write;
    logic [WIDTH-1:0] pick_strobe;
    logic [WIDTH-1:0] pick_data;
    int               pick_dist;
    int               best_dist;

    logic             grant;
    logic             in_access;
    logic             rsp_accept;

    // Round-robin pick: the valid requester closest to rr_ptr going upward with wrap.
    always_comb begin
        best_dist   = N_REQ;
        pick_dist   = 0;
        pick_idx    = '0;
        pick_write  = 1'b0;
        pick_strobe = '0;
        pick_data   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pick_dist = k - int'(rr_ptr_q);
            if (pick_dist < 0) begin
                pick_dist = pick_dist + N_REQ;
            end
            if (i_req_valid[k] && (pick_dist < best_dist)) begin
                best_dist   = pick_dist;
                pick_idx    = PTR_W'(k);
                pick_write  = i_req_write[k];
                pick_strobe = i_req_strobe[k*WIDTH +: WIDTH];
                pick_data   = i_req_data[k*WIDTH +: WIDTH];
            end
        end
        pick_found = (best_dist < N_REQ);
    end

    assign grant     = (state_q == IDLE) && pick_found;
    assign in_access = (state_q == ACCESS);

    // One-hot grant and response-valid vectors.
    always_comb begin
        o_req_ready = '0;
        o_rsp_valid = '0;
        for (int k = 0; k < N_REQ; k++) begin
            o_req_ready[k] = grant && (pick_idx == PTR_W'(k));
            o_rsp_valid[k] = (state_q == RESPONSE) && (cmd_idx_q == PTR_W'(k));
        end
    end

    // Only the owner's ready bit can complete the response; others are masked off.
    assign rsp_accept = |(o_rsp_valid & i_rsp_ready);

    // Bit-field port and response data are forced to zero outside their phases.
    always_comb begin
        o_bit_field_valid      = in_access;
        o_bit_field_read_mask  = (in_access && !cmd_write_q) ? cmd_strobe_q : '0;
        o_bit_field_write_mask = (in_access && cmd_write_q) ? cmd_strobe_q : '0;
        o_bit_field_write_data = (in_access && cmd_write_q) ? cmd_data_q : '0;
        o_rsp_data             = (state_q == RESPONSE) ? rsp_data_q : '0;
    end

    // Next-state logic for the access sequencer and round-robin pointer.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cmd_idx_d    = cmd_idx_q;
        cmd_write_d  = cmd_write_q;
        cmd_strobe_d = cmd_strobe_q;
        cmd_data_d   = cmd_data_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    cmd_idx_d    = pick_idx;
                    cmd_write_d  = pick_write;
                    cmd_strobe_d = pick_strobe;
                    cmd_data_d   = pick_data;
                    rr_ptr_d     = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                // Unstrobed bits of the read data never reach the requester.
                rsp_data_d = cmd_write_q ? '0 : (i_bit_field_read_data & cmd_strobe_q);
                state_d    = RESPONSE;
            end
            RESPONSE: begin
                if (rsp_accept) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any transaction.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            cmd_idx_q    <= '0;
            cmd_write_q  <= 1'b0;
            cmd_strobe_q <= '0;
            cmd_data_q   <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cmd_idx_q    <= cmd_idx_d;
            cmd_write_q  <= cmd_write_d;
            cmd_strobe_q <= cmd_strobe_d;
            cmd_data_q   <= cmd_data_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_rggen_register_access_arbiter.sv
// Bench for rggen_register_access_arbiter: a 2-requester instance driven by a
// vector table, hand sequences and random stimulus against a transaction-level
// model, plus a 4-requester instance for pointer wrap behaviour.
module tb_rggen_register_access_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 2-requester instance
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_ready;
    logic [63:0] req_strobe, req_data;
    logic [31:0] rsp_data, bf_rmask, bf_wmask, bf_wdata, bf_rdata;
    logic        bf_valid;

    // 4-requester instance
    logic         rst4_n;
    logic [3:0]   req4_valid, req4_ready, req4_write, rsp4_valid, rsp4_ready;
    logic [127:0] req4_strobe, req4_data;
    logic [31:0]  rsp4_data, bf4_rmask, bf4_wmask, bf4_wdata, bf4_rdata;
    logic         bf4_valid;

    rggen_register_access_arbiter #(.N_REQ(2), .WIDTH(32)) u_dut2 (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_req_valid            (req_valid),
        .o_req_ready            (req_ready),
        .i_req_write            (req_write),
        .i_req_strobe           (req_strobe),
        .i_req_data             (req_data),
        .o_rsp_valid            (rsp_valid),
        .i_rsp_ready            (rsp_ready),
        .o_rsp_data             (rsp_data),
        .o_bit_field_valid      (bf_valid),
        .o_bit_field_read_mask  (bf_rmask),
        .o_bit_field_write_mask (bf_wmask),
        .o_bit_field_write_data (bf_wdata),
        .i_bit_field_read_data  (bf_rdata)
    );

    rggen_register_access_arbiter #(.N_REQ(4), .WIDTH(32)) u_dut4 (
        .i_clk                  (clk),
        .i_rst_n                (rst4_n),
        .i_req_valid            (req4_valid),
        .o_req_ready            (req4_ready),
        .i_req_write            (req4_write),
        .i_req_strobe           (req4_strobe),
        .i_req_data             (req4_data),
        .o_rsp_valid            (rsp4_valid),
        .i_rsp_ready            (rsp4_ready),
        .o_rsp_data             (rsp4_data),
        .o_bit_field_valid      (bf4_valid),
        .o_bit_field_read_mask  (bf4_rmask),
        .o_bit_field_write_mask (bf4_wmask),
        .o_bit_field_write_data (bf4_wdata),
        .i_bit_field_read_data  (bf4_rdata)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic [1:0]  write;
        logic [31:0] s0, d0, s1, d1;
        logic [1:0]  rrdy;
        logic [31:0] rdata;
        logic [1:0]  e_ready;
        logic        e_bfv;
        logic [31:0] e_rm, e_wm, e_wd;
        logic [1:0]  e_rv;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(
        input logic rst, input logic [1:0] valid, input logic [1:0] write,
        input logic [31:0] s0, input logic [31:0] d0, input logic [31:0] s1,
        input logic [31:0] d1, input logic [1:0] rrdy, input logic [31:0] rdata,
        input logic [1:0] e_ready, input logic e_bfv, input logic [31:0] e_rm,
        input logic [31:0] e_wm, input logic [31:0] e_wd, input logic [1:0] e_rv,
        input logic [31:0] e_rd);
        vec_t v;
        v.rst = rst; v.valid = valid; v.write = write;
        v.s0 = s0; v.d0 = d0; v.s1 = s1; v.d1 = d1;
        v.rrdy = rrdy; v.rdata = rdata;
        v.e_ready = e_ready; v.e_bfv = e_bfv; v.e_rm = e_rm; v.e_wm = e_wm;
        v.e_wd = e_wd; v.e_rv = e_rv; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; req_valid = '0; req_write = '0; req_strobe = '0; req_data = '0;
        rsp_ready = '0; bf_rdata = '0;
        rst4_n = 1'b1; req4_valid = '0; req4_write = '0; req4_strobe = '0; req4_data = '0;
        rsp4_ready = '0; bf4_rdata = '0;
    endtask

    // Hold both instances in reset for two edges, then release.
    task automatic do_reset();
        idle_inputs();
        rst_n  = 1'b0;
        rst4_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rst4_n = 1'b1;
    endtask

    // Drive one cycle of inputs, compare mid-cycle, advance past the next edge.
    task automatic run_row(input vec_t v, input string tag, input int idx);
        rst_n      = v.rst;
        req_valid  = v.valid;
        req_write  = v.write;
        req_strobe = {v.s1, v.s0};
        req_data   = {v.d1, v.d0};
        rsp_ready  = v.rrdy;
        bf_rdata   = v.rdata;
        @(negedge clk);
        chk($sformatf("%s[%0d].req_ready", tag, idx), 32'(req_ready), 32'(v.e_ready));
        chk($sformatf("%s[%0d].bf_valid", tag, idx), 32'(bf_valid), 32'(v.e_bfv));
        chk($sformatf("%s[%0d].read_mask", tag, idx), bf_rmask, v.e_rm);
        chk($sformatf("%s[%0d].write_mask", tag, idx), bf_wmask, v.e_wm);
        chk($sformatf("%s[%0d].write_data", tag, idx), bf_wdata, v.e_wd);
        chk($sformatf("%s[%0d].rsp_valid", tag, idx), 32'(rsp_valid), 32'(v.e_rv));
        chk($sformatf("%s[%0d].rsp_data", tag, idx), rsp_data, v.e_rd);
        @(posedge clk);
        #1;
    endtask

    task automatic run4(input logic rst, input logic [3:0] valid, input logic [3:0] rrdy,
                        input logic [3:0] e_ready, input logic e_bfv, input logic [3:0] e_rv,
                        input int idx);
        rst4_n     = rst;
        req4_valid = valid;
        rsp4_ready = rrdy;
        @(negedge clk);
        chk($sformatf("n4[%0d].req_ready", idx), 32'(req4_ready), 32'(e_ready));
        chk($sformatf("n4[%0d].bf_valid", idx), 32'(bf4_valid), 32'(e_bfv));
        chk($sformatf("n4[%0d].rsp_valid", idx), 32'(rsp4_valid), 32'(e_rv));
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: one outstanding access, aged by cycles since grant.
    int          m_ptr;
    bit          m_active;
    int          m_owner;
    int          m_age;
    bit          m_wr;
    logic [31:0] m_strb, m_data, m_resp;
    bit          e_found;
    int          e_pick;

    localparam logic [31:0] S0 = 32'h0000_FFFF;
    localparam logic [31:0] D0 = 32'h1234_5678;
    localparam logic [31:0] S1 = 32'h0000_00FF;
    localparam logic [31:0] D1 = 32'hCAFE_BABE;
    localparam logic [31:0] Z  = 32'h0;

    initial begin
        idle_inputs();
        do_reset();

        // Basic write, read, alternating grants and an all-zero strobe.
        tbl.push_back(row(1, 2'b00, 2'b00, Z, Z, Z, Z, 2'b00, Z, 2'b00, 0, Z, Z, Z, 2'b00, Z));
        tbl.push_back(row(1, 2'b01, 2'b01, S0, D0, Z, Z, 2'b00, Z, 2'b01, 0, Z, Z, Z, 2'b00, Z));
        tbl.push_back(row(1, 2'b00, 2'b00, Z, Z, Z, Z, 2'b00, Z, 2'b00, 1, Z, S0, D0, 2'b00, Z));
        tbl.push_back(row(1, 2'b00, 2'b00, Z, Z, Z, Z, 2'b01, Z, 2'b00, 0, Z, Z, Z, 2'b01, Z));
        tbl.push_back(row(1, 2'b01, 2'b00, 32'hFF00_FF00, Z, Z, Z, 2'b00, Z,
                          2'b01, 0, Z, Z, Z, 2'b00, Z));
        tbl.push_back(row(1, 2'b00, 2'b00, Z, Z, Z, Z, 2'b00, 32'hAABB_CCDD,
                          2'b00, 1, 32'hFF00_FF00, Z, Z, 2'b00, Z));
        tbl.push_back(row(1, 2'b00, 2'b00, Z, Z, Z, Z, 2'b00, Z,
                          2'b00, 0, Z, Z, Z, 2'b01, 32'hAA00_CC00));
        tbl.push_back(row(1, 2'b00, 2'b00, Z, Z, Z, Z, 2'b01, Z,
                          2'b00, 0, Z, Z, Z, 2'b01, 32'hAA00_CC00));
        tbl.push_back(row(1, 2'b11, 2'b11, S0, D0, S1, D1, 2'b11, Z, 2'b10, 0, Z, Z, Z, 2'b00, Z));
        tbl.push_back(row(1, 2'b11, 2'b11, S0, D0, S1, D1, 2'b11, Z, 2'b00, 1, Z, S1, D1, 2'b00, Z));
        tbl.push_back(row(1, 2'b11, 2'b11, S0, D0, S1, D1, 2'b11, Z, 2'b00, 0, Z, Z, Z, 2'b10, Z));
        tbl.push_back(row(1, 2'b11, 2'b11, S0, D0, S1, D1, 2'b11, Z, 2'b01, 0, Z, Z, Z, 2'b00, Z));
        tbl.push_back(row(1, 2'b11, 2'b11, S0, D0, S1, D1, 2'b11, Z, 2'b00, 1, Z, S0, D0, 2'b00, Z));
        tbl.push_back(row(1, 2'b11, 2'b11, S0, D0, S1, D1, 2'b11, Z, 2'b00, 0, Z, Z, Z, 2'b01, Z));
        tbl.push_back(row(1, 2'b11, 2'b11, S0, D0, S1, D1, 2'b11, Z, 2'b10, 0, Z, Z, Z, 2'b00, Z));
        tbl.push_back(row(1, 2'b11, 2'b11, S0, D0, S1, D1, 2'b11, Z, 2'b00, 1, Z, S1, D1, 2'b00, Z));
        tbl.push_back(row(1, 2'b11, 2'b11, S0, D0, S1, D1, 2'b11, Z, 2'b00, 0, Z, Z, Z, 2'b10, Z));
        tbl.push_back(row(1, 2'b01, 2'b00, Z, Z, Z, Z, 2'b00, Z, 2'b01, 0, Z, Z, Z, 2'b00, Z));
        tbl.push_back(row(1, 2'b00, 2'b00, Z, Z, Z, Z, 2'b00, 32'hFFFF_FFFF,
                          2'b00, 1, Z, Z, Z, 2'b00, Z));
        tbl.push_back(row(1, 2'b00, 2'b00, Z, Z, Z, Z, 2'b01, Z, 2'b00, 0, Z, Z, Z, 2'b01, Z));
        tbl.push_back(row(1, 2'b00, 2'b00, Z, Z, Z, Z, 2'b00, Z, 2'b00, 0, Z, Z, Z, 2'b00, Z));
        foreach (tbl[i]) run_row(tbl[i], "tbl", i);

        // Response held off by the owner while the other requester waits.
        do_reset();
        run_row(row(1, 2'b01, 2'b00, 32'hFFFF_FFFF, Z, Z, Z, 2'b00, Z,
                    2'b01, 0, Z, Z, Z, 2'b00, Z), "hold", 0);
        run_row(row(1, 2'b11, 2'b00, Z, Z, Z, Z, 2'b10, 32'h1357_2468,
                    2'b00, 1, 32'hFFFF_FFFF, Z, Z, 2'b00, Z), "hold", 1);
        for (int i = 0; i < 5; i++) begin
            run_row(row(1, 2'b11, 2'b00, Z, Z, Z, Z, 2'b10, $urandom,
                        2'b00, 0, Z, Z, Z, 2'b01, 32'h1357_2468), "hold", 2 + i);
        end
        run_row(row(1, 2'b11, 2'b00, Z, Z, Z, Z, 2'b11, Z,
                    2'b00, 0, Z, Z, Z, 2'b01, 32'h1357_2468), "hold", 7);
        run_row(row(1, 2'b11, 2'b00, Z, Z, Z, Z, 2'b00, Z, 2'b10, 0, Z, Z, Z, 2'b00, Z), "hold", 8);

        // Reset in RESPONSE, then reset in ACCESS, both abort the access.
        run_row(row(1, 2'b00, 2'b00, Z, Z, Z, Z, 2'b00, Z, 2'b00, 1, Z, Z, Z, 2'b00, Z), "rst", 0);
        run_row(row(0, 2'b00, 2'b00, Z, Z, Z, Z, 2'b00, Z, 2'b00, 0, Z, Z, Z, 2'b10, Z), "rst", 1);
        run_row(row(1, 2'b11, 2'b00, 32'hF0F0_F0F0, Z, Z, Z, 2'b00, Z,
                    2'b01, 0, Z, Z, Z, 2'b00, Z), "rst", 2);
        run_row(row(0, 2'b00, 2'b00, Z, Z, Z, Z, 2'b00, $urandom,
                    2'b00, 1, 32'hF0F0_F0F0, Z, Z, 2'b00, Z), "rst", 3);
        run_row(row(1, 2'b00, 2'b00, Z, Z, Z, Z, 2'b11, Z, 2'b00, 0, Z, Z, Z, 2'b00, Z), "rst", 4);
        run_row(row(1, 2'b10, 2'b00, Z, Z, Z, Z, 2'b00, Z, 2'b10, 0, Z, Z, Z, 2'b00, Z), "rst", 5);

        // Four requesters: pointer wrap and stability across idle cycles.
        do_reset();
        run4(1, 4'b1000, 4'b0000, 4'b1000, 0, 4'b0000, 0);
        run4(1, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 1);
        run4(1, 4'b0000, 4'b1111, 4'b0000, 0, 4'b1000, 2);
        for (int i = 0; i < 3; i++) run4(1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 3 + i);
        run4(1, 4'b1010, 4'b0000, 4'b0010, 0, 4'b0000, 6);
        run4(1, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 7);
        run4(1, 4'b0000, 4'b1111, 4'b0000, 0, 4'b0010, 8);
        for (int i = 0; i < 2; i++) run4(1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 9 + i);
        run4(1, 4'b1011, 4'b0000, 4'b1000, 0, 4'b0000, 11);
        run4(1, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 12);
        run4(1, 4'b0000, 4'b0111, 4'b0000, 0, 4'b1000, 13);
        run4(1, 4'b0000, 4'b1000, 4'b0000, 0, 4'b1000, 14);
        run4(1, 4'b1111, 4'b0000, 4'b0001, 0, 4'b0000, 15);

        // Random traffic against the reference model.
        do_reset();
        m_ptr = 0; m_active = 0; m_owner = 0; m_age = 0; m_wr = 0;
        m_strb = '0; m_data = '0; m_resp = '0;
        for (int c = 0; c < 600; c++) begin
            rst_n      = ($urandom_range(0, 49) != 0);
            req_valid  = 2'($urandom);
            req_write  = 2'($urandom);
            req_strobe = {$urandom, $urandom};
            req_data   = {$urandom, $urandom};
            rsp_ready  = 2'($urandom);
            bf_rdata   = $urandom;

            e_found = 0;
            e_pick  = 0;
            for (int off = 0; off < 2; off++) begin
                if (!e_found && req_valid[(m_ptr + off) % 2]) begin
                    e_found = 1;
                    e_pick  = (m_ptr + off) % 2;
                end
            end

            @(negedge clk);
            chk($sformatf("rnd[%0d].req_ready", c), 32'(req_ready),
                (!m_active && e_found) ? (32'd1 << e_pick) : 32'd0);
            chk($sformatf("rnd[%0d].bf_valid", c), 32'(bf_valid),
                32'(m_active && m_age == 1));
            chk($sformatf("rnd[%0d].read_mask", c), bf_rmask,
                (m_active && m_age == 1 && !m_wr) ? m_strb : 32'd0);
            chk($sformatf("rnd[%0d].write_mask", c), bf_wmask,
                (m_active && m_age == 1 && m_wr) ? m_strb : 32'd0);
            chk($sformatf("rnd[%0d].write_data", c), bf_wdata,
                (m_active && m_age == 1 && m_wr) ? m_data : 32'd0);
            chk($sformatf("rnd[%0d].rsp_valid", c), 32'(rsp_valid),
                (m_active && m_age == 2) ? (32'd1 << m_owner) : 32'd0);
            chk($sformatf("rnd[%0d].rsp_data", c), rsp_data,
                (m_active && m_age == 2) ? m_resp : 32'd0);

            if (!rst_n) begin
                m_active = 0;
                m_ptr    = 0;
            end else if (!m_active) begin
                if (e_found) begin
                    m_active = 1;
                    m_owner  = e_pick;
                    m_age    = 1;
                    m_wr     = req_write[e_pick];
                    m_strb   = req_strobe[e_pick*32 +: 32];
                    m_data   = req_data[e_pick*32 +: 32];
                    m_ptr    = (e_pick + 1) % 2;
                end
            end else if (m_age == 1) begin
                m_resp = m_wr ? 32'd0 : (bf_rdata & m_strb);
                m_age  = 2;
            end else if (rsp_ready[m_owner]) begin
                m_active = 0;
            end

            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
